// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART boot loader.
//   - loader_state_t : frame-parsing FSM states
//   - rx_state_t     : bit-level UART receiver states
//   - HDR_BYTE       : first byte of every program frame
//   - word_addr()    : byte address of the idx-th word above a base address
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] HDR_BYTE       = 8'h55;
  localparam int         LEN_BITS       = 16;
  localparam int         BYTES_PER_WORD = 4;

  // Words are 4 bytes wide; the sum wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver.
//   clk, reset  : system clock, synchronous active-high reset
//   rx          : asynchronous serial input, idle high
//   byte_valid  : one-cycle pulse, data_byte holds the received byte
//   data_byte   : last good byte (held between pulses)
//   frame_err   : one-cycle pulse when the stop bit is sampled low
module uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_reg;
  logic             rx_meta_reg;
  logic             rx_sync_reg;
  logic             rx_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser resets to the idle level so no false edge follows reset.
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      byte_valid  <= 1'b0;
      data_byte   <= 8'h00;
      frame_err   <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            state_reg <= RX_START;
            cnt_reg   <= '0;
          end
        end
        RX_START: begin
          // Mid-bit recheck rejects glitches shorter than half a bit.
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rx_sync_reg) begin
              state_reg   <= RX_DATA;
              bit_idx_reg <= 3'd0;
            end else begin
              state_reg <= RX_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};  // LSB first
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= RX_IDLE;
            if (rx_sync_reg) begin
              byte_valid <= 1'b1;
              data_byte  <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial boot loader: parses framed program images from a UART line and
// writes them word by word into instruction memory, holding the core in
// reset until a frame with a good checksum has been loaded.
// Frame: 0x55, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), XOR checksum.
//   clk, reset  : system clock, synchronous active-high reset
//   rx          : UART serial input (8N1, idle high, asynchronous)
//   imem_write  : one-cycle write strobe to imem
//   imem_addr   : byte address of the word being written
//   imem_data   : word being written
//   cpu_reset   : holds the core in reset while no good image is loaded
//   busy        : frame reception in progress
//   done        : last frame loaded with a good checksum
//   error       : last frame aborted (length, checksum or framing)
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          BAUD      = 115_200,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_write,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PTR_W        = $clog2(DEPTH + 1);
  localparam logic [LEN_BITS:0] DEPTH_MAX = (LEN_BITS + 1)'(DEPTH);

  logic       byte_valid;
  logic [7:0] data_byte;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .data_byte (data_byte),
    .frame_err (frame_err)
  );

  loader_state_t     state_reg;
  logic [7:0]        len_lo_reg;
  logic [PTR_W-1:0]  len_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [1:0]        byte_idx_reg;
  logic [23:0]       word_reg;      // lower three bytes; the fourth arrives with the strobe
  logic [7:0]        chk_reg;

  logic [LEN_BITS:0] n_words;
  logic [PTR_W-1:0]  ptr_next;
  logic              in_frame;

  assign n_words  = {1'b0, data_byte, len_lo_reg};
  assign ptr_next = ptr_reg + PTR_W'(1);
  assign in_frame = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                    (state_reg == ST_DATA)   || (state_reg == ST_CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      len_lo_reg   <= 8'h00;
      len_reg      <= '0;
      ptr_reg      <= '0;
      byte_idx_reg <= 2'd0;
      word_reg     <= 24'h0;
      chk_reg      <= 8'h00;
      imem_write   <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_data    <= 32'h0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_write <= 1'b0;
      if (frame_err && in_frame) begin
        state_reg <= ST_ERR;
        busy      <= 1'b0;
        error     <= 1'b1;
      end else if (byte_valid) begin
        unique case (state_reg)
          ST_IDLE, ST_DONE, ST_ERR: begin
            // A header byte (re)starts a load from any resting state.
            if (data_byte == HDR_BYTE) begin
              state_reg    <= ST_LEN_LO;
              busy         <= 1'b1;
              cpu_reset    <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              chk_reg      <= 8'h00;
              ptr_reg      <= '0;
              byte_idx_reg <= 2'd0;
            end
          end
          ST_LEN_LO: begin
            len_lo_reg <= data_byte;
            state_reg  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            if (n_words > DEPTH_MAX) begin
              state_reg <= ST_ERR;
              busy      <= 1'b0;
              error     <= 1'b1;
            end else if (n_words == '0) begin
              state_reg <= ST_CHECK;
            end else begin
              len_reg   <= n_words[PTR_W-1:0];
              state_reg <= ST_DATA;
            end
          end
          ST_DATA: begin
            chk_reg <= chk_reg ^ data_byte;
            if (byte_idx_reg == 2'd3) begin
              imem_data    <= {data_byte, word_reg};
              imem_addr    <= word_addr(BASE_ADDR, 32'(ptr_reg));
              imem_write   <= 1'b1;
              ptr_reg      <= ptr_next;
              byte_idx_reg <= 2'd0;
              if (ptr_next == len_reg) begin
                state_reg <= ST_CHECK;
              end
            end else begin
              unique case (byte_idx_reg)
                2'd0:    word_reg[7:0]   <= data_byte;
                2'd1:    word_reg[15:8]  <= data_byte;
                default: word_reg[23:16] <= data_byte;
              endcase
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
          ST_CHECK: begin
            busy <= 1'b0;
            if (data_byte == chk_reg) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state_reg <= ST_ERR;
              error     <= 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomised + directed bench for imem_uart_loader. Expected imem writes are
// queued when a frame is issued and popped by an independent monitor.
module tb_imem_uart_loader;

  localparam int          BIT   = 10;   // clocks per UART bit
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        imem_write;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .imem_write(imem_write),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        prev_write = 1'b0;

  // Write monitor: every strobe must match the oldest expected write and
  // never be back-to-back with another strobe.
  always @(negedge clk) begin
    if (imem_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_addr, imem_data} !== mon_exp || prev_write) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h back_to_back=%0b, required addr=%h data=%h",
                   imem_addr, imem_data, prev_write, mon_exp[63:32], mon_exp[31:0]);
        end else begin
          $display("write addr=%h data=%h", imem_addr, imem_data);
        end
      end
    end
    prev_write = imem_write;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = ~bad_stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic glitch();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Reference: N words are written if the length fits and every byte of a word
  // arrived cleanly; done only when nothing aborted and the checksum equals the
  // XOR of all data bytes. bad_idx marks a byte sent with a low stop bit.
  task automatic run_frame(input string name, input logic [7:0] fb[$], input int bad_idx,
                           input int glitch_after);
    int         n;
    int         last;
    logic [7:0] x;
    bit         exp_done;
    n    = int'({fb[2], fb[1]});
    last = (n > DEPTH) ? 2 : fb.size() - 1;
    if (bad_idx >= 0 && bad_idx < last) last = bad_idx;
    x        = 8'h00;
    exp_done = 1'b0;
    if (n <= DEPTH) begin
      for (int j = 0; j < 4 * n; j++) x ^= fb[3 + j];
      if (bad_idx < 0 || bad_idx > 2) begin
        for (int i = 0; i < n; i++) begin
          if (bad_idx < 0 || bad_idx > 6 + 4 * i)
            exp_q.push_back({BASE + 32'(4 * i), fb[6 + 4 * i], fb[5 + 4 * i], fb[4 + 4 * i], fb[3 + 4 * i]});
        end
      end
      if (bad_idx < 0) exp_done = (fb[3 + 4 * n] == x);
    end
    for (int j = 0; j <= last; j++) begin
      send_byte(fb[j], j == bad_idx);
      if (j == 0 && bad_idx != 0) begin
        check({name, "_hdr_busy"}, 32'(busy), 32'd1);
        check({name, "_hdr_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, "_hdr_done"}, 32'(done), 32'd0);
        check({name, "_hdr_error"}, 32'(error), 32'd0);
      end
      if (j == glitch_after) glitch();
    end
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(!exp_done));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    $display("frame %s: n=%0d bytes_sent=%0d expect done=%0b", name, n, last + 1, exp_done);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_write"}, 32'(imem_write), 32'd0);
    check({name, "_addr"}, imem_addr, BASE);
    check({name, "_data"}, imem_data, 32'h0);
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
  endtask

  logic [7:0]  fb[$];
  logic [7:0]  good[$];
  logic [7:0]  chk;
  logic [7:0]  b;
  logic [15:0] n;
  int          bad;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Short low pulse while idle must not start a frame.
    glitch();
    check("idle_glitch_busy", 32'(busy), 32'd0);

    // Two-word image with the correct XOR checksum.
    good = {8'h55, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame("t1_good", good, -1, -1);

    // Same frame, wrong checksum.
    fb = good;
    fb[11] = 8'h00;
    run_frame("t2_badchk", fb, -1, -1);

    // Length above DEPTH.
    fb = {8'h55, 8'h01, 8'h01};
    run_frame("t3_toolong", fb, -1, -1);

    // Junk bytes before a zero-length frame.
    send_byte(8'hAA, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("t4_junk_busy", 32'(busy), 32'd0);
    check("t4_junk_error", 32'(error), 32'd1);
    fb = {8'h55, 8'h00, 8'h00, 8'h00};
    run_frame("t4_empty", fb, -1, -1);

    // Framing error on the third data byte, then a glitch inside a frame.
    run_frame("t5_framing", good, 5, -1);
    run_frame("t5_glitch", good, -1, 1);

    // Reset after two data bytes, then a full reload.
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("t6_reset");
    repeat (4 * BIT) @(negedge clk);
    check("t6_no_write_after_reset", 32'(imem_addr), BASE);
    run_frame("t6_reload", good, -1, -1);

    // Random frames, occasionally with a corrupted checksum or stop bit.
    for (int f = 0; f < 8; f++) begin
      n  = 16'($urandom_range(0, 5));
      fb = {8'h55, n[7:0], n[15:8]};
      chk = 8'h00;
      for (int j = 0; j < 4 * int'(n); j++) begin
        b = 8'($urandom);
        fb.push_back(b);
        chk ^= b;
      end
      if ($urandom_range(0, 3) == 0) chk ^= 8'($urandom_range(1, 255));
      fb.push_back(chk);
      bad = -1;
      if (n != 0 && $urandom_range(0, 4) == 0) bad = 3 + int'($urandom_range(0, 4 * int'(n) - 1));
      run_frame($sformatf("rand%0d", f), fb, bad, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
